// File: rtl/sqr2_pkg.sv
// Shared types, FP16 field constants and operand normalisation for the sqr2 squarer.
package sqr2_pkg;

    localparam int unsigned FP_W   = 16;
    localparam int unsigned EXP_W  = 5;
    localparam int unsigned MANT_W = 10;
    localparam int unsigned SIG_W  = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * SIG_W;
    localparam int          EXP_MAX = 31;
    localparam int          BIAS    = 15;

    localparam logic [FP_W-1:0] PINF = 16'h7C00;
    localparam logic [FP_W-1:0] QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    typedef struct packed {
        logic [SIG_W-1:0]  sig;
        logic signed [7:0] exp;
    } norm_t;

    // Significand with explicit leading 1 and unbiased exponent; subnormals are shifted up.
    function automatic norm_t fp16_norm(input logic [EXP_W-1:0] e,
                                        input logic [MANT_W-1:0] f,
                                        input int bias);
        norm_t r;
        int    ev;
        if (e == '0) begin
            r.sig = {1'b0, f};
            ev    = 1 - bias;
            for (int unsigned i = 0; i < MANT_W; i++) begin
                if (!r.sig[SIG_W-1]) begin
                    r.sig = r.sig << 1;
                    ev    = ev - 1;
                end
            end
        end else begin
            r.sig = {1'b1, f};
            ev    = int'(e) - bias;
        end
        r.exp = 8'(ev);
        return r;
    endfunction

endpackage

// File: rtl/sqr2_seq_mul11.sv
// 11x11 unsigned shift-add multiplier, one multiplier bit per cycle, MSB first.
module seq_mul11 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_start,
    input  logic [10:0] i_a,
    input  logic [10:0] i_b,
    output logic        o_busy,
    output logic        o_done,
    output logic [21:0] o_prod
);

    logic [10:0] r_mcand;
    logic [10:0] r_mplier;
    logic [21:0] r_prod;
    logic [3:0]  r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_clr) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= 4'd11;
        end else if (r_cnt != '0) begin
            r_prod   <= (r_prod << 1) + (r_mplier[10] ? {11'b0, r_mcand} : '0);
            r_mplier <= r_mplier << 1;
            r_cnt    <= r_cnt - 4'd1;
        end
    end

    // o_done marks the cycle whose closing edge writes the final partial product.
    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == 4'd1);
    assign o_prod = r_prod;

endmodule

// File: rtl/sqr2.sv
// FP16 squarer with a shared bidirectional operand/result bus and RNE rounding.
module sqr2 #(
    parameter int          BIAS = sqr2_pkg::BIAS,
    parameter logic [15:0] QNAN = sqr2_pkg::QNAN
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    inout  logic [15:0] IO_DATA,
    output logic        RESULT,
    output logic        IS_NAN,
    output logic        IS_PINF,
    output logic        IS_ZERO
);
    import sqr2_pkg::*;

    state_t r_state, w_next;

    logic              r_result, r_nan, r_pinf, r_zero;
    logic [15:0]       r_data;
    logic signed [7:0] r_exp;
    logic [20:0]       r_m;
    logic              r_sticky;

    logic        w_start, w_special, w_do_norm, w_do_round, w_clear;
    logic        w_mul_busy, w_mul_done;
    logic [21:0] w_prod;

    logic [14:0] w_mag;
    logic [4:0]  w_e;
    logic [9:0]  w_f;
    logic        w_is_nan, w_is_inf, w_is_zero;
    norm_t       w_norm;

    assign w_mag     = 15'(IO_DATA);
    assign w_e       = w_mag[14:10];
    assign w_f       = w_mag[9:0];
    assign w_is_nan  = (int'(w_e) == EXP_MAX) && (w_f != '0);
    assign w_is_inf  = (int'(w_e) == EXP_MAX) && (w_f == '0);
    assign w_is_zero = (w_mag == '0);
    assign w_norm    = fp16_norm(w_e, w_f, BIAS);

    seq_mul11 u_mul (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (w_clear),
        .i_start (w_start),
        .i_a     (w_norm.sig),
        .i_b     (w_norm.sig),
        .o_busy  (w_mul_busy),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_special  = 1'b0;
        w_do_norm  = 1'b0;
        w_do_round = 1'b0;
        w_clear    = 1'b0;
        if (!ENABLE) begin
            w_next  = IDLE;
            w_clear = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_is_nan || w_is_inf || w_is_zero) begin
                        w_special = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_start = 1'b1;
                        w_next  = MUL;
                    end
                end
                MUL:   if (w_mul_busy && w_mul_done) w_next = NORM;
                NORM: begin
                    w_do_norm = 1'b1;
                    w_next    = ROUND;
                end
                ROUND: begin
                    w_do_round = 1'b1;
                    w_next     = DONE;
                end
                DONE:    w_next = DONE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Normalisation: bit 21 set means the square reached [2,4), so one extra exponent step.
    logic signed [7:0] w_be;
    logic [20:0]       w_m_n;
    logic              w_sticky_n;

    assign w_be       = 8'(2 * int'(r_exp) + int'(w_prod[21]) + BIAS);
    assign w_m_n      = w_prod[21] ? w_prod[21:1] : w_prod[20:0];
    assign w_sticky_n = w_prod[21] & w_prod[0];

    // Rounding: subnormal results are denormalised first so one RNE path covers both ranges.
    logic        w_sub, w_ovf, w_inc, w_guard, w_stk;
    logic [5:0]  w_sh;
    logic [41:0] w_ext;
    logic [10:0] w_mant11;
    logic [11:0] w_rnd;
    logic [7:0]  w_bm1;
    logic [15:0] w_base, w_sum, w_rdata;

    always_comb begin
        w_sub    = (int'(r_exp) < 1);
        w_sh     = w_sub ? 6'(1 - int'(r_exp)) : '0;
        w_ext    = {r_m, 21'b0} >> w_sh;
        w_mant11 = w_ext[41:31];
        w_guard  = w_ext[30];
        w_stk    = (|w_ext[29:0]) | r_sticky;
        w_inc    = w_guard & (w_stk | w_mant11[0]);
        w_rnd    = {1'b0, w_mant11} + {11'b0, w_inc};
        w_bm1    = 8'(r_exp) - 8'd1;
        w_base   = w_sub ? '0 : {1'b0, w_bm1[4:0], 10'b0};
        w_sum    = w_base + {4'b0, w_rnd};
        w_ovf    = (int'(r_exp) >= EXP_MAX) || (w_sum >= PINF);
        w_rdata  = w_ovf ? PINF : w_sum;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_result <= 1'b0;
            r_nan    <= 1'b0;
            r_pinf   <= 1'b0;
            r_zero   <= 1'b0;
            r_data   <= '0;
            r_exp    <= '0;
            r_m      <= '0;
            r_sticky <= 1'b0;
        end else if (w_clear) begin
            r_result <= 1'b0;
            r_nan    <= 1'b0;
            r_pinf   <= 1'b0;
            r_zero   <= 1'b0;
            r_data   <= '0;
        end else if (w_special) begin
            r_result <= 1'b1;
            r_nan    <= w_is_nan;
            r_pinf   <= w_is_inf;
            r_zero   <= w_is_zero;
            r_data   <= w_is_nan ? QNAN : (w_is_inf ? PINF : '0);
        end else if (w_start) begin
            r_exp <= w_norm.exp;
        end else if (w_do_norm) begin
            r_exp    <= w_be;
            r_m      <= w_m_n;
            r_sticky <= w_sticky_n;
        end else if (w_do_round) begin
            r_result <= 1'b1;
            r_pinf   <= w_ovf;
            r_zero   <= !w_ovf && (w_sum == '0);
            r_data   <= w_rdata;
        end
    end

    assign IO_DATA = r_result ? r_data : 'z;
    assign RESULT  = r_result;
    assign IS_NAN  = r_nan;
    assign IS_PINF = r_pinf;
    assign IS_ZERO = r_zero;

endmodule

// File: tb/tb_sqr2.sv
// Randomised and directed checks of sqr2 against an exact-arithmetic FP16 squaring model.
module tb_sqr2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ENABLE = 1'b0;
    logic [15:0] host_drv = 16'h0000;
    wire  [15:0] io_bus;
    logic        RESULT, IS_NAN, IS_PINF, IS_ZERO;

    int n_cmp = 0;
    int n_err = 0;

    assign io_bus = RESULT ? 16'hzzzz : host_drv;

    sqr2 #(.BIAS(15), .QNAN(16'h7E00)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ENABLE  (ENABLE),
        .IO_DATA (io_bus),
        .RESULT  (RESULT),
        .IS_NAN  (IS_NAN),
        .IS_PINF (IS_PINF),
        .IS_ZERO (IS_ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact square as M * 2^k, then round-to-nearest-even onto the FP16 grid.
    task automatic model(input logic [15:0] x, output logic [15:0] r,
                         output logic [2:0] flags, output logic special);
        int     e, f, k, p, eu, qe, d;
        longint m, n, rem, half;
        e = int'(x[14:10]);
        f = int'(x[9:0]);
        special = 1'b0;
        flags = 3'b000;
        if (e == 31) begin
            special = 1'b1;
            if (f != 0) begin r = 16'h7E00; flags = 3'b100; end
            else        begin r = 16'h7C00; flags = 3'b010; end
        end else if (e == 0 && f == 0) begin
            special = 1'b1;
            r = 16'h0000;
            flags = 3'b001;
        end else begin
            if (e == 0) begin m = longint'(f) * longint'(f); k = -48; end
            else begin m = longint'(1024 + f) * longint'(1024 + f); k = 2 * e - 50; end
            p = 0;
            for (int i = 0; i < 24; i++) if (m >= (64'sd1 <<< i)) p = i;
            eu = p + k;
            if (eu < -14) eu = -14;
            qe = eu - 10;
            d  = qe - k;
            if (d <= 0) n = m <<< (-d);
            else begin
                n    = m >>> d;
                rem  = m - (n <<< d);
                half = 64'sd1 <<< (d - 1);
                if (rem > half || (rem == half && n[0])) n = n + 1;
            end
            if (n == 2048) begin n = 1024; eu = eu + 1; end
            if (eu > 15) begin
                r = 16'h7C00;
                flags = 3'b010;
            end else begin
                if (n < 1024) r = 16'(n);
                else          r = 16'(((eu + 15) << 10) + int'(n - 1024));
                if (r == 16'h0000) flags = 3'b001;
            end
        end
    endtask

    task automatic run(input logic [15:0] x, output logic [15:0] got);
        logic [15:0] er;
        logic [2:0]  ef;
        logic        sp;
        model(x, er, ef, sp);
        @(negedge CLK);
        host_drv = x;
        ENABLE   = 1'b1;
        @(posedge CLK); #1;
        if (sp) begin
            check("lat_special", 32'(RESULT), 32'd1);
        end else begin
            check("lat_n0", 32'(RESULT), 32'd0);
            repeat (12) @(posedge CLK);
            #1 check("lat_n12", 32'(RESULT), 32'd0);
            @(posedge CLK); #1;
            check("lat_n13", 32'(RESULT), 32'd1);
        end
        got = io_bus;
        check($sformatf("data_%h", x), 32'(io_bus), 32'(er));
        check($sformatf("flags_%h", x), 32'({IS_NAN, IS_PINF, IS_ZERO}), 32'(ef));
        repeat (3) @(posedge CLK);
        #1 check("hold", 32'({RESULT, IS_NAN, IS_PINF, IS_ZERO, io_bus}), 32'({1'b1, ef, er}));
        @(negedge CLK);
        ENABLE   = 1'b0;
        host_drv = 16'hA5C3;
        @(posedge CLK); #1;
        check("release", 32'({RESULT, IS_NAN, IS_PINF, IS_ZERO, io_bus}), 32'({4'b0000, 16'hA5C3}));
    endtask

    logic [15:0] vec [11] = '{16'h4000, 16'h3E00, 16'hC200, 16'h3C01, 16'h5CB0, 16'h1400,
                              16'h0001, 16'h7E01, 16'hFC00, 16'h8000, 16'h4200};
    logic [15:0] want [11] = '{16'h4400, 16'h4080, 16'h4880, 16'h3C02, 16'h7C00, 16'h0010,
                               16'h0000, 16'h7E00, 16'h7C00, 16'h0000, 16'h4880};

    initial begin
        logic [15:0] got, x;

        #3 RST = 1'b1;
        #2;
        check("reset", 32'({RESULT, IS_NAN, IS_PINF, IS_ZERO, io_bus}), 32'({4'b0000, 16'h0000}));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 11; i++) begin
            run(vec[i], got);
            check($sformatf("spec_%h", vec[i]), 32'(got), 32'(want[i]));
        end

        // Abort: ENABLE sampled low at edge N+5.
        @(negedge CLK);
        host_drv = 16'h3E00;
        ENABLE   = 1'b1;
        @(posedge CLK);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        ENABLE   = 1'b0;
        host_drv = 16'h1234;
        @(posedge CLK); #1;
        check("abort", 32'({RESULT, IS_NAN, IS_PINF, IS_ZERO, io_bus}), 32'({4'b0000, 16'h1234}));
        repeat (12) @(posedge CLK);
        #1 check("abort_quiet", 32'({RESULT, io_bus}), 32'({1'b0, 16'h1234}));

        // Reset mid-MUL, then reset while holding a result.
        @(negedge CLK);
        host_drv = 16'h4000;
        ENABLE   = 1'b1;
        repeat (4) @(posedge CLK);
        #2 RST = 1'b1;
        #1 check("rst_mul", 32'({RESULT, IS_NAN, IS_PINF, IS_ZERO}), 32'd0);
        @(negedge CLK);
        ENABLE = 1'b0;
        RST    = 1'b0;
        @(negedge CLK);
        host_drv = 16'hFC00;
        ENABLE   = 1'b1;
        @(posedge CLK); #1;
        check("pre_rst_done", 32'({RESULT, IS_PINF}), 32'b11);
        #2 RST = 1'b1;
        #1 check("rst_done", 32'({RESULT, IS_NAN, IS_PINF, IS_ZERO, io_bus}), 32'({4'b0000, 16'hFC00}));
        @(negedge CLK);
        ENABLE = 1'b0;
        RST    = 1'b0;
        run(16'h4200, got);
        check("post_rst", 32'(got), 32'h4880);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) x = 16'($urandom);
            else x = {1'($urandom), 5'($urandom_range(0, 22)), 10'($urandom)};
            run(x, got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sqr2.md
SQR2 -- requirements
Module: sqr2

Interface
REQ-001 SHALL have parameter BIAS, default 15, FP16 exponent bias.
REQ-002 SHALL have parameter QNAN, default 16'h7E00, canonical quiet-NaN result.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port ENABLE, input, 1, host request, held high for the whole transaction.
REQ-006 SHALL have port IO_DATA, inout, 16.
  - Host drives the FP16 operand while RESULT=0.
  - Block drives the FP16 result while RESULT=1.
REQ-007 SHALL have port RESULT, output, 1, result valid on IO_DATA.
REQ-008 SHALL have port IS_NAN, output, 1, result is NaN.
REQ-009 SHALL have port IS_PINF, output, 1, result is +inf (input inf or overflow).
REQ-010 SHALL have port IS_ZERO, output, 1, result is +0 (input zero or full underflow).

Function
REQ-011 SHALL compute x*x for FP16 x, IEEE round-to-nearest-even; result sign always 0 except NaN.
REQ-012 SHALL use FSM states IDLE, MUL, NORM, ROUND, DONE.
REQ-013 SHALL in IDLE, at first edge N with ENABLE=1:
  - capture IO_DATA;
  - classify operand;
  - go to MUL for finite nonzero operands, DONE otherwise.
REQ-014 SHALL for specials, at edge N, load the DONE result:
  - NaN (exp=31, mant!=0) -> QNAN, IS_NAN=1;
  - ±inf -> 16'h7C00, IS_PINF=1;
  - ±0 -> 16'h0000, IS_ZERO=1.
REQ-015 SHALL normalise subnormal operands to an 11-bit significand with leading 1 and an adjusted unbiased exponent E.
REQ-016 SHALL form the 22-bit product s*s by shift-add over exactly 11 MUL cycles (edges N+1..N+11), one multiplier bit per cycle.
REQ-017 SHALL in NORM (edge N+12):
  - if product bit 21 is set, shift right 1 and use exponent 2E+1, else 2E;
  - biased exponent = exponent+BIAS.
REQ-018 SHALL in ROUND (edge N+13), by biased exponent be:
  - be>=31 -> 16'h7C00, IS_PINF=1;
  - be<=0 -> right-shift by 1-be into subnormal, sticky-OR shifted-out bits, then RNE;
  - rounding carry into exponent 31 -> +inf;
  - zero after rounding -> IS_ZERO=1.
REQ-019 SHALL assert RESULT registered:
  - finite nonzero: high after edge N+13;
  - specials: high after edge N.
REQ-020 SHALL drive IO_DATA only while RESULT=1; high-Z otherwise.
REQ-021 SHALL remain in DONE with the result and flags stable while ENABLE=1, ignoring IO_DATA.
REQ-022 SHALL, when ENABLE=0 is sampled in any state, next edge:
  - go to IDLE;
  - clear RESULT and all flags;
  - release the bus.
REQ-023 SHALL start a new transaction only after at least one cycle with ENABLE=0.
REQ-024 SHALL keep at most one of IS_NAN, IS_PINF, IS_ZERO high.

Reset
REQ-025 SHALL on RST=1, immediately and asynchronously:
  - state=IDLE;
  - RESULT, IS_NAN, IS_PINF, IS_ZERO = 0;
  - IO_DATA high-Z;
  - product, counter and operand registers = 0.
REQ-026 SHALL abort any in-flight transaction on reset mid-operation; first post-reset transaction behaves as from power-up.

Structure
REQ-027 SHALL place in package sqr2_pkg:
  - FSM state enum;
  - FP16 field widths, EXP_MAX=31, BIAS;
  - constants PINF=16'h7C00 and QNAN.
REQ-028 SHALL isolate the 11x11 shift-add multiplier in sub-module seq_mul11 with start/busy/done handshake, 11-cycle latency.

Verification
REQ-029 SHALL cover normal squaring:
  - 16'h4000 (2.0) -> 16'h4400, RESULT after edge N+13;
  - 16'h3E00 (1.5) -> 16'h4080;
  - 16'hC200 (-3.0) -> 16'h4880.
REQ-030 SHALL cover rounding: 16'h3C01 -> 16'h3C02 (2^-20 term rounded away, RNE).
REQ-031 SHALL cover overflow: 16'h5CB0 (300.0) -> 16'h7C00, IS_PINF=1.
REQ-032 SHALL cover underflow:
  - 16'h1400 (2^-10) -> 16'h0010 subnormal;
  - 16'h0001 -> 16'h0000, IS_ZERO=1.
REQ-033 SHALL cover specials, each with RESULT after edge N:
  - 16'h7E01 -> QNAN, IS_NAN=1;
  - 16'hFC00 -> 16'h7C00, IS_PINF=1;
  - 16'h8000 -> 16'h0000, IS_ZERO=1.
REQ-034 SHALL cover abort and reset:
  - ENABLE dropped at edge N+5 -> IDLE next edge, bus Z, no RESULT;
  - RST mid-MUL -> outputs 0 at once;
  - following 16'h4200 -> 16'h4880.
